serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial, LSB-first unsigned subtractor that computes `diff = a - b` over `WIDTH` clock cycles.

- Uses a single one-bit subtract cell and a registered borrow.
- Sits alongside the combinational adder cells in the arithmetic library as the area-minimal inverse operation.
- Operands are captured on a start/ready handshake; completion is signalled by a one-cycle done pulse.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `ready`=1.
- `a`  in  WIDTH  minuend; captured on the cycle `start` is accepted.
- `b`  in  WIDTH  subtrahend; captured with `a`.
- `ready`  out  1  high in IDLE only; combinational from state.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; high in DONE.
- `diff`  out  WIDTH  result `(a - b) mod 2^WIDTH`.
- `borrow_out`  out  1  final borrow; 1 iff `a < b` (unsigned).

## Operation
FSM states are IDLE, RUN and DONE.

- **IDLE:** `ready`=1. On `start`=1:
  - load shift registers `sa`←`a`, `sb`←`b`;
  - clear the borrow flop `br`;
  - clear the bit counter `cnt`;
  - go to RUN.
- **RUN:** each cycle processes bit 0 of `sa`/`sb`:
  - `d = sa[0] ^ sb[0] ^ br`
  - `br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`
  - `sa` and `sb` shift right by one.
  - The result register shifts right with `d` entering at the MSB.
  - `cnt` increments. When `cnt == WIDTH-1`, go to DONE.
- **DONE:** `done`=1 for exactly one cycle.
  - `diff` holds the full result; `borrow_out` = final `br`.
  - Go to IDLE unconditionally.
- `start` outside IDLE is ignored: no queuing and no effect on the operation in progress.
- `diff` and `borrow_out` are held stable from DONE until the next accepted start.
  - On the next accepted start they are not cleared; they update only when the next operation reaches DONE.
  - `diff` and `borrow_out` are updated together, on the RUN→DONE edge.
- `a` and `b` may change freely after capture.
- Counter width is `$clog2(WIDTH)`. No other wrap-around exists; `cnt` resets to 0 on every accept.

## Timing
- **Reset:** asynchronous assertion forces
  - state=IDLE;
  - `ready`=1, `busy`=0, `done`=0;
  - `diff`=0, `borrow_out`=0;
  - internal `sa`, `sb`, `br`, `cnt` all 0.
- **Reset mid-operation:** the operation is abandoned. No `done` pulse is generated, and outputs take their reset values immediately. Deassertion is synchronised externally; the block is ready on the first edge after release.
- **Latency:** start accepted at edge k.
  - RUN occupies the cycles after edges k … k+WIDTH-1.
  - DONE (`done`=1) occupies the cycle after edge k+WIDTH.
  - The block is IDLE again after edge k+WIDTH+1.
- **Throughput:** one operation per `WIDTH+2` cycles. A `start` held high continuously is re-accepted in the first IDLE cycle after DONE.
- `ready`, `busy` and `done` are mutually exclusive and exactly one is high at all times.

## Structure
Shared arithmetic package holds:
- the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the default `WIDTH` constant.

Sub-module `full_subtractor` is a combinational one-bit cell:
- inputs `x`, `y`, `bin`;
- outputs `d`, `bout`, implementing the equations above;
- instantiated once.

The top-level holds the FSM, shift registers, borrow flop and counter.

## Test plan
All scenarios use `WIDTH`=8 unless stated otherwise.

- **Basic subtraction:** `a`=200, `b`=55, start pulse → `done` at start edge +9; `diff`=145, `borrow_out`=0.
- **Underflow:** `a`=5, `b`=10 → `diff`=251, `borrow_out`=1.
- **Corner operands:** run each pair, then sweep 500 random pairs against the reference model `(a-b) & 8'hFF`, borrow `a<b`.
  - `a`=0, `b`=0 → `diff`=0, `borrow_out`=0.
  - `a`=255, `b`=255 → `diff`=0, `borrow_out`=0.
  - `a`=0, `b`=1 → `diff`=255, `borrow_out`=1.
- **Start while busy:** start with 100-1, then pulse `start` with `a`=9, `b`=9 at RUN cycle 3 → single `done`, `diff`=99, no second operation.
- **Reset mid-operation:** assert `rst_n`=0 at RUN cycle 4 → all outputs 0 and `ready`=1 immediately, no `done`. A subsequent 7-3 yields 4.
- **Back-to-back and WIDTH=2:**
  - Hold `start` high with `a`/`b` changing each cycle → accepts exactly every 10 cycles, each result matches the operands at its accept edge, and `diff` is stable between `done` pulses.
  - Repeat with `WIDTH`=2: 1-2 → `diff`=3, `borrow_out`=1, `done` at start edge +3.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready handshake, operands and result of the serial subtractor.
// The master drives a request; the slave (the subtractor) answers.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational subtract cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: one subtract cell, a registered
// borrow and a counter step through WIDTH bits per operation.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = cell_bout;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        // The visible result only moves on the final bit, so it stays stable during RUN.
        if (cnt_q == LAST_BIT) begin
          diff_d   = {cell_d, res_q[WIDTH-1:1]};
          borrow_d = cell_bout;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule
